// File: rtl/usb3_scramble_gen.sv
// ----------------------------------------------------------------------------
// usb3_scramble_gen
//
// USB 3.0 transmit scrambler with SKP ordered-set scheduling. It sits between
// the link-layer TX mux and the 8b/10b encoder / PIPE TX interface.
//   - D symbols are XORed with the USB 3.0 LFSR (X^16+X^5+X^4+X^3+1, Galois).
//     COM reseeds the LFSR, SKP holds it, and other K symbols advance it.
//   - Transmitted symbols are counted. Every SKP_INTERVAL symbols one SKP
//     ordered set is queued, up to SKP_QMAX sets.
//   - Queued sets are sent as all-SKP beats in cycles with no transfer.
//
// Optional feature macro: USB3_SKP_FORCE_EN
//   defined   : raw_ready drops while the queue is saturated, so a SKP beat is
//               forced into continuous traffic.
//   undefined : raw_ready is constant 1. Requests beyond SKP_QMAX are dropped
//               and flagged on err_overflow.
//
// Parameters
//   BYTES        symbols per beat (2 or 4)
//   SKP_INTERVAL symbols between SKP requests (8..65535)
//   SKP_QMAX     maximum queued SKP ordered sets (1..7)
//   LFSR_SEED    LFSR value after reset, on COM, and while disabled
//
// Ports
//   local_clk     in   clock
//   reset_n       in   asynchronous active-low reset
//   enable        in   scrambling / SKP scheduling active (low = bypass)
//   skp_inhibit   in   suppresses SKP injection and forced stalls
//   raw_data      in   8*BYTES input symbols, byte 0 transmitted first
//   raw_datak     in   K flag per input byte
//   raw_valid     in   input beat valid
//   raw_ready     out  block accepts a beat
//   proc_data     out  scrambled symbols (registered)
//   proc_datak    out  K flags out (registered)
//   proc_valid    out  output beat valid (registered)
//   proc_skp      out  output beat is an injected SKP beat (registered)
//   skp_queued    out  SKP ordered sets waiting in the queue
//   err_overflow  out  one-cycle pulse when a SKP request is dropped
// ----------------------------------------------------------------------------
module usb3_scramble_gen #(
   parameter int unsigned BYTES        = 4,
   parameter int unsigned SKP_INTERVAL = 80,
   parameter int unsigned SKP_QMAX     = 4,
   parameter logic [15:0] LFSR_SEED    = 16'hFFFF
) (
   input  logic               local_clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               skp_inhibit,
   input  logic [8*BYTES-1:0] raw_data,
   input  logic [BYTES-1:0]   raw_datak,
   input  logic               raw_valid,
   output logic               raw_ready,
   output logic [8*BYTES-1:0] proc_data,
   output logic [BYTES-1:0]   proc_datak,
   output logic               proc_valid,
   output logic               proc_skp,
   output logic [2:0]         skp_queued,
   output logic               err_overflow
);

   localparam int unsigned W         = 8 * BYTES;
   localparam logic [7:0]  K_COM     = 8'hBC;   // K28.5
   localparam logic [7:0]  K_SKP     = 8'h3C;   // K28.1
   // One ordered set is two SKP symbols, so a beat carries BYTES/2 sets.
   localparam logic [2:0]  SETS_BEAT = 3'(BYTES / 2);
   localparam logic [2:0]  QMAX      = 3'(SKP_QMAX);

   // Eight serial steps of the Galois LFSR: shift left, feedback into 0,3,4,5.
   function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
      logic [15:0] t;
      t = s;
      for (int b = 0; b < 8; b++) begin
         t = {t[14:0], 1'b0} ^ (t[15] ? 16'h0039 : 16'h0000);
      end
      return t;
   endfunction

   // Scrambling byte: data bit b is XORed with LFSR bit 15-b.
   function automatic logic [7:0] lfsr_byte(input logic [15:0] s);
      logic [7:0] r;
      for (int b = 0; b < 8; b++) begin
         r[b] = s[15-b];
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [15:0]  lfsr_q,       lfsr_d;
   logic [15:0]  cnt_q,        cnt_d;
   logic [2:0]   q_q,          q_d;
   logic [W-1:0] data_q,       data_d;
   logic [BYTES-1:0] datak_q,  datak_d;
   logic         valid_q,      valid_d;
   logic         skp_q,        skp_d;
   logic         ovf_q,        ovf_d;

   // Combinational helpers
   logic [W-1:0] scr_data;
   logic [15:0]  lfsr_chain;
   logic         transfer;
   logic         inject;
   logic         inc;
   logic [2:0]   dec;
   logic [16:0]  cnt_sum;
   logic [3:0]   q_sum;

`ifdef USB3_SKP_FORCE_EN
   // Saturated queue stalls the source so that a SKP beat can be forced in.
   assign raw_ready = !(enable && (q_q == QMAX) && !skp_inhibit);
`else
   assign raw_ready = 1'b1;
`endif

   assign transfer = raw_valid && raw_ready;
   // A stalled cycle also counts as "no transfer", so a forced stall
   // with a non-empty queue becomes an injection beat.
   assign inject   = enable && (q_q != 3'd0) && !skp_inhibit && !transfer;

   // ---------------------------------------------------------------------
   // Per-lane scrambler, lane state chained in ascending byte order
   // ---------------------------------------------------------------------
   // NOTE: combinational blocks use blocking '=' and give every output a
   // default first, so the chained value flows lane to lane and no latch
   // is inferred on any path.
   always_comb begin
      logic [15:0] st;
      st       = lfsr_q;
      scr_data = raw_data;
      for (int i = 0; i < BYTES; i++) begin
         if (raw_datak[i]) begin
            if (raw_data[8*i +: 8] == K_COM) begin
               st = LFSR_SEED;
            end else if (raw_data[8*i +: 8] != K_SKP) begin
               st = lfsr_adv8(st);
            end
         end else begin
            scr_data[8*i +: 8] = raw_data[8*i +: 8] ^ lfsr_byte(st);
            st = lfsr_adv8(st);
         end
      end
      lfsr_chain = st;
   end

   // ---------------------------------------------------------------------
   // Symbol counter, SKP queue and output beat selection
   // ---------------------------------------------------------------------
   always_comb begin
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      data_d  = data_q;     // idle beats keep the last data on the bus
      datak_d = datak_q;
      valid_d = 1'b0;
      skp_d   = 1'b0;
      ovf_d   = 1'b0;
      inc     = 1'b0;
      dec     = 3'd0;
      cnt_sum = {1'b0, cnt_q} + 17'(BYTES);
      q_sum   = {1'b0, q_q};

      if (!enable) begin
         // Bypass: pass beats through and park the scheduler.
         lfsr_d = LFSR_SEED;
         cnt_d  = 16'd0;
         q_d    = 3'd0;
         if (raw_valid) begin
            data_d  = raw_data;
            datak_d = raw_datak;
            valid_d = 1'b1;
         end
      end else begin
         if (transfer) begin
            lfsr_d  = lfsr_chain;
            data_d  = scr_data;
            datak_d = raw_datak;
            valid_d = 1'b1;
            if (cnt_sum >= 17'(SKP_INTERVAL)) begin
               cnt_d = 16'(cnt_sum - 17'(SKP_INTERVAL));
               inc   = 1'b1;
            end else begin
               cnt_d = cnt_sum[15:0];
            end
         end else if (inject) begin
            // A lone set on a 4-byte beat still fills the whole beat.
            dec     = (q_q < SETS_BEAT) ? q_q : SETS_BEAT;
            data_d  = {BYTES{K_SKP}};
            datak_d = '1;
            valid_d = 1'b1;
            skp_d   = 1'b1;
         end

         // dec never exceeds q_q, so the difference cannot underflow.
         q_sum = {1'b0, q_q} - {1'b0, dec} + {3'b000, inc};
         if (q_sum > {1'b0, QMAX}) begin
            q_d   = QMAX;
            ovf_d = 1'b1;
         end else begin
            q_d = q_sum[2:0];
         end
      end
   end

   // NOTE: sequential state uses non-blocking '<=' only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge local_clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q  <= LFSR_SEED;
         cnt_q   <= 16'd0;
         q_q     <= 3'd0;
         data_q  <= '0;
         datak_q <= '0;
         valid_q <= 1'b0;
         skp_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         data_q  <= data_d;
         datak_q <= datak_d;
         valid_q <= valid_d;
         skp_q   <= skp_d;
         ovf_q   <= ovf_d;
      end
   end

   assign proc_data    = data_q;
   assign proc_datak   = datak_q;
   assign proc_valid   = valid_q;
   assign proc_skp     = skp_q;
   assign skp_queued   = q_q;
   assign err_overflow = ovf_q;

endmodule

// File: tb/tb_usb3_scramble_gen.sv
// ----------------------------------------------------------------------------
// tb_usb3_scramble_gen
//
// Directed bench for usb3_scramble_gen with default parameters (BYTES=4,
// SKP_INTERVAL=80, SKP_QMAX=4, LFSR_SEED=FFFF). Expected scrambler bytes for a
// D00 stream starting from the seed are
// FF 17 C0 14 B2 E7 02 82 72 6E 28.
// The saturation section follows USB3_SKP_FORCE_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_usb3_scramble_gen;

   logic        local_clk;
   logic        reset_n;
   logic        enable;
   logic        skp_inhibit;
   logic [31:0] raw_data;
   logic [3:0]  raw_datak;
   logic        raw_valid;
   logic        raw_ready;
   logic [31:0] proc_data;
   logic [3:0]  proc_datak;
   logic        proc_valid;
   logic        proc_skp;
   logic [2:0]  skp_queued;
   logic        err_overflow;

   int checks = 0;
   int errors = 0;

   usb3_scramble_gen #(
      .BYTES        (4),
      .SKP_INTERVAL (80),
      .SKP_QMAX     (4),
      .LFSR_SEED    (16'hFFFF)
   ) dut (
      .local_clk    (local_clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .skp_inhibit  (skp_inhibit),
      .raw_data     (raw_data),
      .raw_datak    (raw_datak),
      .raw_valid    (raw_valid),
      .raw_ready    (raw_ready),
      .proc_data    (proc_data),
      .proc_datak   (proc_datak),
      .proc_valid   (proc_valid),
      .proc_skp     (proc_skp),
      .skp_queued   (skp_queued),
      .err_overflow (err_overflow)
   );

   initial local_clk = 1'b0;
   always #5 local_clk = ~local_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one beat, clock it, and settle just after the edge.
   task automatic beat(input logic v, input logic [31:0] d, input logic [3:0] k);
      raw_valid = v;
      raw_data  = d;
      raw_datak = k;
      @(posedge local_clk);
      #1;
   endtask

   initial begin
      int pulses;
      int q_exp;

      reset_n     = 1'b0;
      enable      = 1'b0;
      skp_inhibit = 1'b0;
      raw_data    = '0;
      raw_datak   = '0;
      raw_valid   = 1'b0;

      // ---------------- reset state ----------------
      #2;
      check("rst_data",  proc_data,           32'h0);
      check("rst_datak", {28'h0, proc_datak}, 32'h0);
      check("rst_valid", {31'h0, proc_valid}, 32'h0);
      check("rst_skp",   {31'h0, proc_skp},   32'h0);
      check("rst_q",     {29'h0, skp_queued}, 32'h0);
      check("rst_err",   {31'h0, err_overflow}, 32'h0);
      check("rst_ready", {31'h0, raw_ready},  32'h1);
      @(posedge local_clk);
      @(posedge local_clk);
      #1;
      reset_n = 1'b1;

      // ---------------- scramble sequence ----------------
      enable = 1'b1;
      beat(1'b1, 32'h0000_00BC, 4'b0001);          // COM,D00,D00,D00
      check("seq0_data",  proc_data,           32'hC017_FFBC);
      check("seq0_datak", {28'h0, proc_datak}, 32'h1);
      check("seq0_valid", {31'h0, proc_valid}, 32'h1);
      check("seq0_skp",   {31'h0, proc_skp},   32'h0);
      beat(1'b1, 32'h0, 4'b0000);
      check("seq1_data",  proc_data, 32'h02E7_B214);
      beat(1'b1, 32'h0, 4'b0000);
      check("seq2_data",  proc_data, 32'h286E_7282);

      // Idle in bypass: no valid, bus holds, scrambler reseeds.
      enable = 1'b0;
      beat(1'b0, 32'h0, 4'b0000);
      check("idle_valid", {31'h0, proc_valid}, 32'h0);
      check("idle_hold",  proc_data, 32'h286E_7282);

      // ---------------- mid-beat COM ----------------
      enable = 1'b1;
      beat(1'b1, 32'h0000_BC00, 4'b0010);          // D00,COM,D00,D00
      check("midcom_data",  proc_data,           32'h17FF_BCFF);
      check("midcom_datak", {28'h0, proc_datak}, 32'h2);
      beat(1'b1, 32'h0, 4'b0000);
      check("midcom_next",  proc_data, 32'hE7B2_14C0);

      // ---------------- bypass ----------------
      enable = 1'b0;
      beat(1'b1, 32'h1234_5678, 4'b1000);
      check("byp_data",  proc_data,           32'h1234_5678);
      check("byp_datak", {28'h0, proc_datak}, 32'h8);
      check("byp_valid", {31'h0, proc_valid}, 32'h1);
      check("byp_q",     {29'h0, skp_queued}, 32'h0);

      // enable rising: first beat scrambled from the seed
      enable = 1'b1;
      beat(1'b1, 32'h0, 4'b0000);
      check("enrise_data", proc_data, 32'h14C0_17FF);

      // ---------------- SKP scheduling ----------------
      enable = 1'b0;
      beat(1'b0, 32'h0, 4'b0000);                  // clear counter
      enable = 1'b1;
      for (int i = 0; i < 19; i++) beat(1'b1, 32'h0, 4'b0000);
      check("sch_q19", {29'h0, skp_queued}, 32'h0);
      beat(1'b1, 32'h0000_00BC, 4'b0001);          // beat 20 reseeds too
      check("sch_b20_data", proc_data,           32'hC017_FFBC);
      check("sch_q20",      {29'h0, skp_queued}, 32'h1);
      beat(1'b0, 32'h0, 4'b0000);
      check("sch_skp",      {31'h0, proc_skp},   32'h1);
      check("sch_valid",    {31'h0, proc_valid}, 32'h1);
      check("sch_data",     proc_data,           32'h3C3C_3C3C);
      check("sch_datak",    {28'h0, proc_datak}, 32'hF);
      check("sch_q0",       {29'h0, skp_queued}, 32'h0);
      beat(1'b1, 32'h0, 4'b0000);                  // LFSR untouched by SKP beat
      check("sch_cont",     proc_data,           32'h02E7_B214);
      check("sch_cont_skp", {31'h0, proc_skp},   32'h0);
      beat(1'b0, 32'h0, 4'b0000);
      check("sch_idle_valid", {31'h0, proc_valid}, 32'h0);
      check("sch_idle_hold",  proc_data,           32'h02E7_B214);

      // ---------------- saturation ----------------
      enable = 1'b0;
      beat(1'b0, 32'h0, 4'b0000);
      enable = 1'b1;
      pulses = 0;
      for (int i = 0; i < 80; i++) begin
         beat(1'b1, 32'h0, 4'b0000);
         if (err_overflow) pulses++;
      end
      check("sat_q80", {29'h0, skp_queued}, 32'h4);
`ifdef USB3_SKP_FORCE_EN
      check("sat_ready_low", {31'h0, raw_ready}, 32'h0);
      beat(1'b1, 32'h0, 4'b0000);                  // stalled beat becomes SKP
      check("sat_force_skp", {31'h0, proc_skp},     32'h1);
      check("sat_force_q",   {29'h0, skp_queued},   32'h2);
      check("sat_force_rdy", {31'h0, raw_ready},    32'h1);
      check("sat_force_err", {31'h0, err_overflow}, 32'h0);
      beat(1'b1, 32'h0, 4'b0000);
      check("sat_resume_valid", {31'h0, proc_valid}, 32'h1);
      check("sat_resume_skp",   {31'h0, proc_skp},   32'h0);
      check("sat_pulses", 32'(pulses), 32'h0);
      q_exp = 2;
`else
      for (int i = 0; i < 20; i++) begin
         check("sat_ready", {31'h0, raw_ready}, 32'h1);
         beat(1'b1, 32'h0, 4'b0000);
         if (err_overflow) pulses++;
      end
      check("sat_err_last", {31'h0, err_overflow}, 32'h1);
      check("sat_pulses",   32'(pulses),           32'h1);
      check("sat_q_hold",   {29'h0, skp_queued},   32'h4);
      beat(1'b1, 32'h0, 4'b0000);
      check("sat_err_clr",  {31'h0, err_overflow}, 32'h0);
      q_exp = 4;
`endif

      // ---------------- skp_inhibit ----------------
      skp_inhibit = 1'b1;
      for (int i = 0; i < 3; i++) begin
         beat(1'b0, 32'h0, 4'b0000);
         check("inh_skp",   {31'h0, proc_skp},   32'h0);
         check("inh_valid", {31'h0, proc_valid}, 32'h0);
         check("inh_q",     {29'h0, skp_queued}, 32'(q_exp));
         check("inh_ready", {31'h0, raw_ready},  32'h1);
      end
      skp_inhibit = 1'b0;
      while (q_exp > 0) begin
         beat(1'b0, 32'h0, 4'b0000);
         q_exp = (q_exp > 2) ? q_exp - 2 : 0;
         check("drain_skp", {31'h0, proc_skp},   32'h1);
         check("drain_q",   {29'h0, skp_queued}, 32'(q_exp));
      end
      beat(1'b0, 32'h0, 4'b0000);
      check("drain_done", {31'h0, proc_valid}, 32'h0);

      // ---------------- asynchronous reset mid-stream ----------------
      beat(1'b1, 32'h0, 4'b0000);
      #3;
      reset_n = 1'b0;
      #1;
      check("arst_data",  proc_data,           32'h0);
      check("arst_valid", {31'h0, proc_valid}, 32'h0);
      check("arst_datak", {28'h0, proc_datak}, 32'h0);
      check("arst_q",     {29'h0, skp_queued}, 32'h0);
      #2;
      reset_n = 1'b1;
      #1;
      check("arst_ready", {31'h0, raw_ready},  32'h1);
      beat(1'b1, 32'h0, 4'b0000);
      check("arst_seed",  proc_data,           32'h14C0_17FF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
